// File: rtl/acc_router_pkg.sv
// Shared constants for the accelerator router: bus width, default FIFO sizing
// and accelerator identifiers used by the bus controller and its FIFOs.
package acc_router_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned FIFO_DEPTH     = 16;
  localparam int unsigned FIFO_ADDR_W    = 4;
  localparam int unsigned FIFO_AF_THRESH = 14;
  localparam int unsigned FIFO_AE_THRESH = 2;

  typedef enum logic [1:0] {
    ACC_FFT = 2'd0,
    ACC_FIR = 2'd1,
    ACC_IIR = 2'd2
  } acc_id_e;

endpackage

// File: rtl/acc_fifo_ram.sv
// FIFO storage: one synchronous write port and one synchronous registered read port.
// Only the read-data register is reset; the array itself is left uninitialised.
module acc_fifo_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write to rd_addr is not bypassed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/acc_data_fifo.sv
// Accelerator-side data FIFO between the bus controller and one accelerator.
// Registered occupancy, empty/full/watermark flags and sticky error flags.
module acc_data_fifo
  import acc_router_pkg::*;
#(
  parameter int unsigned DATA_W    = acc_router_pkg::DATA_W,
  parameter int unsigned DEPTH     = acc_router_pkg::FIFO_DEPTH,
  parameter int unsigned ADDR_W    = acc_router_pkg::FIFO_ADDR_W,
  parameter int unsigned AF_THRESH = acc_router_pkg::FIFO_AF_THRESH,
  parameter int unsigned AE_THRESH = acc_router_pkg::FIFO_AE_THRESH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              put_req,
  input  logic [DATA_W-1:0] data_in,
  input  logic              get_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clear_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              put_ok_c;
  logic              get_ok_c;
  logic [CNT_W-1:0]  count_nxt_c;

  // Accept decisions use the registered (pre-edge) flags only.
  always_comb begin
    put_ok_c    = put_req & (~full | get_req);
    get_ok_c    = get_req & ~empty;
    count_nxt_c = count;
    case ({put_ok_c, get_ok_c})
      2'b10:   count_nxt_c = count + CNT_W'(1);
      2'b01:   count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Flags are derived from the next count so they always agree with count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      empty          <= 1'b1;
      full           <= 1'b0;
      almost_empty   <= 1'b1;
      almost_full    <= 1'b0;
      data_out_valid <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (put_ok_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (get_ok_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count          <= count_nxt_c;
      empty          <= (count_nxt_c == '0);
      full           <= (count_nxt_c == CNT_W'(DEPTH));
      almost_empty   <= (count_nxt_c <= CNT_W'(AE_THRESH));
      almost_full    <= (count_nxt_c >= CNT_W'(AF_THRESH));
      data_out_valid <= get_ok_c;
      // A new error in the same cycle as clear_err keeps the bit set.
      overflow       <= (put_req & ~put_ok_c) | (overflow & ~clear_err);
      underflow      <= (get_req & ~get_ok_c) | (underflow & ~clear_err);
    end
  end

  acc_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (put_ok_c),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (get_ok_c),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule
